csr_unit: RTL and testbench

- Machine-mode CSR file and trap controller for the RV32 core, sitting in the execute stage beside the ALU.
- Performs Zicsr read-modify-write with correct set/clear/suppress semantics.
- Sequences trap entry (exceptions, interrupts) and mret, and keeps 64-bit cycle/instret counters.
- Includes a WFI sleep FSM that stalls the pipeline until an enabled interrupt is pending.

---
 rtl/csr_unit_pkg.sv | 69 ++++++
 rtl/csr_unit_counter.sv | 40 ++++
 rtl/csr_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_csr_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, bit
// positions, cause codes, funct3 encodings and the WFI FSM states.
package csr_unit_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  // mip / mie bit positions
  localparam int unsigned IRQ_MSI = 3;
  localparam int unsigned IRQ_MTI = 7;
  localparam int unsigned IRQ_MEI = 11;

  // Writable bits of mie
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // Interrupt cause codes
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  // Exception cause codes
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

  // Zicsr funct3 encodings
  typedef enum logic [2:0] {
    OP_RW  = 3'b001,
    OP_RS  = 3'b010,
    OP_RC  = 3'b011,
    OP_RWI = 3'b101,
    OP_RSI = 3'b110,
    OP_RCI = 3'b111
  } csr_op_e;

  // WFI sleep FSM
  typedef enum logic {
    WFI_RUN   = 1'b0,
    WFI_SLEEP = 1'b1
  } wfi_state_e;

  // Highest-priority pending interrupt: MEI > MSI > MTI
  function automatic logic [3:0] irq_code(input logic mei, input logic msi);
    if (mei)      return CAUSE_MEI;
    else if (msi) return CAUSE_MSI;
    else          return CAUSE_MTI;
  endfunction

endpackage

// File: rtl/csr_unit_counter.sv
// CNT_WIDTH-bit event counter with independent 32-bit lo/hi write ports.
// A write to either half replaces that half and suppresses the increment.
module csr_counter
  import csr_unit_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [63:0]          cur, nxt;

  // Next count: work in 64 bits so both halves are addressable for any width
  always_comb begin
    cur = 64'(cnt_q);
    nxt = cur;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) nxt[31:0]  = wdata_i;
      if (wr_hi_i) nxt[63:32] = wdata_i;
    end else if (inc_i) begin
      nxt = cur + 64'd1;
    end
    cnt_d   = nxt[CNT_WIDTH-1:0];
    value_o = cur;
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller: Zicsr read-modify-write,
// trap entry / mret sequencing, mcycle/minstret and the WFI sleep FSM.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1,
  parameter int unsigned CNT_WIDTH   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_src,
  input  logic        csr_src_zero,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret,
  input  logic        wfi,
  input  logic        instr_retire,
  input  logic        int_ok,
  input  logic [31:0] int_pc,
  input  logic        irq_software,
  input  logic        irq_timer,
  input  logic        irq_external,
  output logic        trap_taken,
  output logic [31:0] trap_target,
  output logic [31:0] mret_target,
  output logic        wfi_stall
);

  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q,      mie_d;
  logic [31:0] mtvec_q,    mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q,     mepc_d;
  logic [31:0] mcause_q,   mcause_d;
  logic [31:0] mtval_q,    mtval_d;

  wfi_state_e  wfi_state_q, wfi_state_d;

  logic [63:0] mcycle_val, minstret_val;
  logic [31:0] mstatus_val, mip_val, pend;
  logic [31:0] old_val, wdata;
  logic        addr_known, addr_ro, wr_op, csr_we, irq_take, mret_do;
  logic [3:0]  trap_code;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign mip_val     = {20'b0, irq_external, 3'b0, irq_timer, 3'b0, irq_software, 3'b0};
  assign pend        = mip_val & mie_q;

  // Read mux: pre-write value of the addressed CSR
  always_comb begin
    old_val    = '0;
    addr_known = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   old_val = mstatus_val;
      CSR_MISA:      old_val = MISA_VAL;
      CSR_MIE:       old_val = mie_q;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MTVAL:     old_val = mtval_q;
      CSR_MIP:       old_val = mip_val;
      CSR_MCYCLE:    old_val = mcycle_val[31:0];
      CSR_MCYCLEH:   old_val = mcycle_val[63:32];
      CSR_MINSTRET:  old_val = minstret_val[31:0];
      CSR_MINSTRETH: old_val = minstret_val[63:32];
      CSR_MVENDORID: old_val = '0;
      CSR_MARCHID:   old_val = '0;
      CSR_MIMPID:    old_val = '0;
      CSR_MHARTID:   old_val = HART_ID;
      default:       addr_known = 1'b0;
    endcase
  end

  // Write data and write intent; set/clear with a zero source never write
  always_comb begin
    wr_op = 1'b0;
    wdata = '0;
    case (csr_op)
      OP_RW, OP_RWI: begin
        wr_op = 1'b1;
        wdata = csr_src;
      end
      OP_RS, OP_RSI: begin
        wr_op = !csr_src_zero;
        wdata = old_val | csr_src;
      end
      OP_RC, OP_RCI: begin
        wr_op = !csr_src_zero;
        wdata = old_val & ~csr_src;
      end
      default: ;
    endcase
  end

  assign addr_ro     = (csr_addr[11:10] == 2'b11);
  assign csr_rdata   = (csr_valid && addr_known) ? old_val : '0;
  assign illegal_csr = csr_valid && (!addr_known || (addr_ro && wr_op));

  // Trap decision uses only architectural state and inputs, never csr_rdata
  assign irq_take   = mstatus_mie_q && int_ok && (|pend) && !exc_valid;
  assign trap_taken = exc_valid || irq_take;
  assign trap_code  = exc_valid ? exc_cause : irq_code(pend[IRQ_MEI], pend[IRQ_MSI]);
  assign mret_do    = mret && !trap_taken;
  assign csr_we     = csr_valid && wr_op && !illegal_csr && !trap_taken && !mret_do;

  assign trap_target = {mtvec_q[31:2], 2'b00} +
                       ((mtvec_q[0] && !exc_valid) ? {26'b0, trap_code, 2'b00} : 32'b0);
  assign mret_target = mepc_q;

  // Architectural next state: trap > mret > CSR write
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (trap_taken) begin
      mepc_d         = exc_valid ? {exc_pc[31:2], 2'b00} : {int_pc[31:2], 2'b00};
      mcause_d       = {!exc_valid, 27'b0, trap_code};
      mtval_d        = exc_valid ? exc_tval : '0;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_do) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wdata[MSTATUS_MIE];
          mstatus_mpie_d = wdata[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wdata & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = {wdata[31:2], 1'b0, wdata[0] & VECTORED_EN};
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = {wdata[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wdata;
        CSR_MTVAL:    mtval_d    = wdata;
        default: ;
      endcase
    end
  end

  // Architectural CSR registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && (csr_addr == CSR_MCYCLE)),
    .wr_hi_i (csr_we && (csr_addr == CSR_MCYCLEH)),
    .wdata_i (wdata),
    .value_o (mcycle_val)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (instr_retire),
    .wr_lo_i (csr_we && (csr_addr == CSR_MINSTRET)),
    .wr_hi_i (csr_we && (csr_addr == CSR_MINSTRETH)),
    .wdata_i (wdata),
    .value_o (minstret_val)
  );

  // WFI FSM state register
  always_ff @(posedge clk) begin
    if (rst) wfi_state_q <= WFI_RUN;
    else     wfi_state_q <= wfi_state_d;
  end

  // WFI FSM next state; wake on any pending enabled interrupt regardless of MIE
  always_comb begin
    wfi_state_d = wfi_state_q;
    wfi_stall   = 1'b0;
    case (wfi_state_q)
      WFI_RUN: begin
        if (wfi && !(|pend)) wfi_state_d = WFI_SLEEP;
      end
      WFI_SLEEP: begin
        wfi_stall = 1'b1;
        if (|pend) wfi_state_d = WFI_RUN;
      end
      default: wfi_state_d = WFI_RUN;
    endcase
  end

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_src;
  logic        csr_src_zero;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret;
  logic        wfi;
  logic        instr_retire;
  logic        int_ok;
  logic [31:0] int_pc;
  logic        irq_software;
  logic        irq_timer;
  logic        irq_external;
  logic        trap_taken;
  logic [31:0] trap_target;
  logic [31:0] mret_target;
  logic        wfi_stall;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  csr_unit #(
    .HART_ID     (32'h0),
    .MISA_VAL    (32'h4000_0100),
    .MTVEC_RESET (32'h0),
    .VECTORED_EN (1'b1),
    .CNT_WIDTH   (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_valid    (csr_valid),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_src      (csr_src),
    .csr_src_zero (csr_src_zero),
    .csr_rdata    (csr_rdata),
    .illegal_csr  (illegal_csr),
    .exc_valid    (exc_valid),
    .exc_cause    (exc_cause),
    .exc_pc       (exc_pc),
    .exc_tval     (exc_tval),
    .mret         (mret),
    .wfi          (wfi),
    .instr_retire (instr_retire),
    .int_ok       (int_ok),
    .int_pc       (int_pc),
    .irq_software (irq_software),
    .irq_timer    (irq_timer),
    .irq_external (irq_external),
    .trap_taken   (trap_taken),
    .trap_target  (trap_target),
    .mret_target  (mret_target),
    .wfi_stall    (wfi_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_valid = 0; csr_op = 3'b000; csr_addr = '0; csr_src = '0; csr_src_zero = 1;
    exc_valid = 0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret = 0; wfi = 0; instr_retire = 0; int_ok = 0; int_pc = '0;
    irq_software = 0; irq_timer = 0; irq_external = 0;
  endtask

  // Drive a CSR instruction; zero-source flag follows the source value
  task automatic csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src);
    csr_valid = 1; csr_op = op; csr_addr = addr; csr_src = src; csr_src_zero = (src == 0);
  endtask

  // Side-effect-free read (CSRRS with zero source), then settle
  task automatic rd(input logic [11:0] addr);
    csr(3'b010, addr, 32'h0);
    #1;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] val);
    csr(3'b001, addr, val);
    tick();
    csr_valid = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    rd(12'h300); check("rst_mstatus", csr_rdata, 32'h0000_1800);
    rd(12'h305); check("rst_mtvec", csr_rdata, 32'h0);
    rd(12'h301); check("misa", csr_rdata, 32'h4000_0100);
    check("rst_stall", {31'b0, wfi_stall}, 32'h0);
    check("rst_trap", {31'b0, trap_taken}, 32'h0);
    csr_valid = 0; #1;
    check("rdata_novalid", csr_rdata, 32'h0);

    // mscratch read-modify-write and suppressed set/clear
    csr(3'b001, 12'h340, 32'hDEAD_BEEF); #1;
    check("rw_old", csr_rdata, 32'h0);
    tick();
    rd(12'h340); check("rs0_read1", csr_rdata, 32'hDEAD_BEEF);
    tick();
    rd(12'h340); check("rs0_read2", csr_rdata, 32'hDEAD_BEEF);
    csr(3'b011, 12'h340, 32'h0); tick();
    rd(12'h340); check("rc0_nowrite", csr_rdata, 32'hDEAD_BEEF);
    csr(3'b110, 12'h340, 32'h0000_0010); tick();
    rd(12'h340); check("rsi_set", csr_rdata, 32'hDEAD_BEFF);
    csr(3'b011, 12'h340, 32'h0000_000F); tick();
    rd(12'h340); check("rc_clear", csr_rdata, 32'hDEAD_BEF0);

    // Write masks
    wr(12'h341, 32'h0000_0123);
    rd(12'h341); check("mepc_mask", csr_rdata, 32'h0000_0120);
    wr(12'h305, 32'h0000_0103);
    rd(12'h305); check("mtvec_mask", csr_rdata, 32'h0000_0101);
    wr(12'h344, 32'h0000_0888);
    rd(12'h344); check("mip_ro_bits", csr_rdata, 32'h0);

    // Vectored external interrupt; CSR write in the same cycle is dropped
    wr(12'h304, 32'h0000_0800);
    wr(12'h300, 32'h0000_0008);
    rd(12'h300); check("mstatus_mie", csr_rdata, 32'h0000_1808);
    irq_external = 1; int_ok = 1; int_pc = 32'h0000_0400;
    csr(3'b001, 12'h340, 32'h1111_1111); #1;
    check("irq_taken", {31'b0, trap_taken}, 32'h1);
    check("irq_target", trap_target, 32'h0000_012C);
    tick();
    idle();
    rd(12'h340); check("trap_drop_wr", csr_rdata, 32'hDEAD_BEF0);
    rd(12'h342); check("irq_mcause", csr_rdata, 32'h8000_000B);
    rd(12'h341); check("irq_mepc", csr_rdata, 32'h0000_0400);
    rd(12'h343); check("irq_mtval", csr_rdata, 32'h0);
    rd(12'h300); check("irq_mstatus", csr_rdata, 32'h0000_1880);

    // mret restores MIE
    csr_valid = 0; mret = 1; #1;
    check("mret_target", mret_target, 32'h0000_0400);
    check("mret_notrap", {31'b0, trap_taken}, 32'h0);
    tick(); mret = 0;
    rd(12'h300); check("mret_mstatus", csr_rdata, 32'h0000_1888);

    // Exception beats a simultaneous enabled timer interrupt
    wr(12'h304, 32'h0000_0080);
    irq_timer = 1; int_ok = 1; int_pc = 32'h0000_0600;
    exc_valid = 1; exc_cause = 4'd11; exc_pc = 32'h0000_0200; exc_tval = 32'h0000_0055; #1;
    check("exc_taken", {31'b0, trap_taken}, 32'h1);
    check("exc_target", trap_target, 32'h0000_0100);
    tick();
    idle();
    rd(12'h342); check("exc_mcause", csr_rdata, 32'h0000_000B);
    rd(12'h341); check("exc_mepc", csr_rdata, 32'h0000_0200);
    rd(12'h343); check("exc_mtval", csr_rdata, 32'h0000_0055);
    rd(12'h300); check("exc_mstatus", csr_rdata, 32'h0000_1880);

    // MSI outranks MTI
    csr_valid = 0; mret = 1; tick(); mret = 0;
    wr(12'h304, 32'h0000_0888);
    irq_timer = 1; irq_software = 1; int_ok = 1; int_pc = 32'h0000_0500; #1;
    check("msi_target", trap_target, 32'h0000_010C);
    tick();
    idle();
    rd(12'h342); check("msi_mcause", csr_rdata, 32'h8000_0003);
    csr_valid = 0; mret = 1; #1;
    check("mret_target2", mret_target, 32'h0000_0500);
    tick(); mret = 0;

    // mcycle carry into the high half
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00); check("mcycle_wr", csr_rdata, 32'hFFFF_FFFF);
    tick();
    rd(12'hB00); check("mcycle_wrap", csr_rdata, 32'h0);
    tick();
    rd(12'hB80); check("mcycleh_carry", csr_rdata, 32'h1);

    // minstret write wins over retire in the same cycle
    csr(3'b001, 12'hB02, 32'h5); instr_retire = 1; tick();
    rd(12'hB02); check("minstret_wr", csr_rdata, 32'h5);
    tick(); instr_retire = 0;
    rd(12'hB02); check("minstret_inc", csr_rdata, 32'h6);

    // Read-only and unknown addresses
    csr(3'b001, 12'hF14, 32'h0000_1234); #1;
    check("ro_illegal", {31'b0, illegal_csr}, 32'h1);
    tick();
    rd(12'hF14);
    check("ro_read_legal", {31'b0, illegal_csr}, 32'h0);
    check("mhartid_kept", csr_rdata, 32'h0);
    csr(3'b001, 12'h7C0, 32'h1); #1;
    check("unk_illegal", {31'b0, illegal_csr}, 32'h1);
    check("unk_rdata", csr_rdata, 32'h0);
    tick();

    // WFI sleep and wake without trap (MIE=0)
    wr(12'h300, 32'h0);
    rd(12'h300); check("mstatus_clr", csr_rdata, 32'h0000_1800);
    csr_valid = 0; wfi = 1; #1;
    check("wfi_same_cyc", {31'b0, wfi_stall}, 32'h0);
    tick(); wfi = 0; #1;
    check("wfi_sleep", {31'b0, wfi_stall}, 32'h1);
    tick();
    check("wfi_hold", {31'b0, wfi_stall}, 32'h1);
    irq_timer = 1; int_ok = 1; #1;
    check("wake_notrap", {31'b0, trap_taken}, 32'h0);
    check("wake_cyc_stall", {31'b0, wfi_stall}, 32'h1);
    tick();
    check("woke", {31'b0, wfi_stall}, 32'h0);
    wfi = 1; tick(); wfi = 0;
    check("wfi_nop_pend", {31'b0, wfi_stall}, 32'h0);

    // Reset while sleeping
    irq_timer = 0; int_ok = 0; wfi = 1; tick(); wfi = 0;
    check("wfi_sleep2", {31'b0, wfi_stall}, 32'h1);
    rst = 1; tick(); rst = 0; #1;
    check("rst_wake", {31'b0, wfi_stall}, 32'h0);
    rd(12'h304); check("rst_mie", csr_rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
